// File: rtl/limber_gnrl_rr_arbbuf_pkg.sv
// Shared constants, types and helpers for the Limber round-robin arbiter buffer.
package limber_gnrl_rr_arbbuf_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_DW   = 32;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Requester-ID width; a single requester bit still needs one ID bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/limber_gnrl_dffl.sv
// Generic load-enabled flops: plain (no reset, powers up at 0) and async active-low reset.
module limber_gnrl_dffl #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         lden,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_r = '0;

   always_ff @(posedge clk) begin
      if (lden) q_r <= d;
   end

   assign q = q_r;

endmodule

module limber_gnrl_dfflr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lden,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= '0;
      else if (lden) q <= d;
   end

endmodule

// File: rtl/limber_gnrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module limber_gnrl_rr_pick
   import limber_gnrl_rr_arbbuf_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int IW   = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_id,
   output logic            any
);

   localparam logic [IW:0] NREQ_W = NREQ[IW:0];

   logic [NREQ-1:0] rot;
   logic [IW-1:0]   off;
   logic [IW:0]     sum;

   always_comb begin
      // Doubling the vector lets a plain shift act as a rotate by ptr.
      rot = NREQ'({req, req} >> ptr);
      off = '0;
      any = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IW'(i);
            any = 1'b1;
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      gnt_id = sum[IW-1:0];
      gnt    = any ? (NREQ'(1) << gnt_id) : '0;
   end

endmodule

// File: rtl/limber_gnrl_rr_arbbuf.sv
// Round-robin arbiter feeding one shared holding register (data + requester ID).
// Note for timing: o_rdy reaches i_rdy combinationally; o_vld/o_dat/o_id are registered.
module limber_gnrl_rr_arbbuf
   import limber_gnrl_rr_arbbuf_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   parameter  int DW   = DEF_DW,
   localparam int IW   = id_width(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    i_vld,
   output logic [NREQ-1:0]    i_rdy,
   input  logic [NREQ*DW-1:0] i_dat,
   output logic               o_vld,
   input  logic               o_rdy,
   output logic [DW-1:0]      o_dat,
   output logic [IW-1:0]      o_id
);

   localparam logic [IW:0] NREQ_W = NREQ[IW:0];

   logic            ld;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_id;
   logic            any;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   ptr_d;
   logic [IW:0]     ptr_inc;
   logic [DW-1:0]   dat_d;
   state_e          state_q;
   state_e          state_d;

   assign ld      = ~o_vld | o_rdy;
   // Masking with rst_n keeps requesters from seeing an accept while state is held in reset.
   assign req     = i_vld & {NREQ{ld & rst_n}};
   assign i_rdy   = gnt;
   assign state_q = o_vld ? ST_FULL : ST_EMPTY;

   limber_gnrl_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   always_comb begin
      state_d = state_q;
      if (any)        state_d = ST_FULL;
      else if (o_rdy) state_d = ST_EMPTY;

      ptr_inc = {1'b0, gnt_id} + {{IW{1'b0}}, 1'b1};
      if (ptr_inc == NREQ_W) ptr_inc = '0;
      ptr_d = ptr_inc[IW-1:0];

      dat_d = i_dat[gnt_id*DW +: DW];
   end

   limber_gnrl_dfflr #(.W(1)) u_vld_q (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (1'b1),
      .d     (state_d == ST_FULL),
      .q     (o_vld)
   );

   limber_gnrl_dfflr #(.W(IW)) u_ptr_q (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (any),
      .d     (ptr_d),
      .q     (ptr)
   );

   limber_gnrl_dffl #(.W(DW)) u_dat_q (
      .clk  (clk),
      .lden (any),
      .d    (dat_d),
      .q    (o_dat)
   );

   limber_gnrl_dffl #(.W(IW)) u_id_q (
      .clk  (clk),
      .lden (any),
      .d    (gnt_id),
      .q    (o_id)
   );

endmodule
